// File: rtl/inout_lab_if.sv
// Board-pin bundle for the PS/2 + 7-segment lab: keyboard lines in, display and LEDs out.
interface inout_lab_if;
  logic        PS2_CLK;
  logic        PS2_DATA;
  logic [6:0]  SEG;
  logic [7:0]  AN;
  logic        DP;
  logic [15:0] LED;

  modport master (output PS2_CLK, output PS2_DATA, input SEG, input AN, input DP, input LED);
  modport slave  (input PS2_CLK, input PS2_DATA, output SEG, output AN, output DP, output LED);
endinterface

// File: rtl/inout_lab.sv
// PS/2 keyboard lab top: frame receiver, make/break decoder, scan-code to ASCII lookup,
// BCD press counter and an 8-digit multiplexed 7-segment scanner.
module inout_lab #(
  parameter int DIGIT_CYCLES   = 100000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        CLK100MHZ,
  input  logic        BTNC,
  inout_lab_if.slave  io
);

  localparam int DIV_W = $clog2(DIGIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIGIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES - 1);

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity(input logic [8:0] v);
    return ^v;
  endfunction

  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic             r_ps2c_s1, r_ps2c_s2, r_ps2c_s3;
  logic             r_ps2d_s1, r_ps2d_s2;
  logic [9:0]       r_frame;
  logic [3:0]       r_bit_cnt;
  logic [TO_W-1:0]  r_idle_cnt;
  logic             r_rx_valid;
  logic [7:0]       r_rx_byte;
  logic             r_err;
  logic [7:0]       r_led_byte;
  logic [7:0]       r_code;
  logic             r_held, r_brk, r_ovf;
  logic [3:0]       r_cnt_lo, r_cnt_hi;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_digit;
  logic [6:0]       r_seg;
  logic [7:0]       r_an;
  logic [15:0]      r_led;

  logic             w_ps2_fall;
  logic [7:0]       w_ascii;
  logic [3:0]       w_nib;
  logic             w_blank;
  logic [6:0]       w_seg;

  assign w_ps2_fall = r_ps2c_s3 & ~r_ps2c_s2;
  assign w_ascii    = scan_to_ascii(r_code);

  // Two-stage synchronisers plus a third clock stage for edge detection.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      r_ps2c_s1 <= 1'b0;
      r_ps2c_s2 <= 1'b0;
      r_ps2c_s3 <= 1'b0;
      r_ps2d_s1 <= 1'b0;
      r_ps2d_s2 <= 1'b0;
    end else begin
      r_ps2c_s1 <= io.PS2_CLK;
      r_ps2c_s2 <= r_ps2c_s1;
      r_ps2c_s3 <= r_ps2c_s2;
      r_ps2d_s1 <= io.PS2_DATA;
      r_ps2d_s2 <= r_ps2d_s1;
    end
  end

  // Frame receiver: shifts bits in LSB-first and judges the frame on the stop bit.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      r_frame    <= 10'd0;
      r_bit_cnt  <= 4'd0;
      r_idle_cnt <= '0;
      r_rx_valid <= 1'b0;
      r_rx_byte  <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_ps2_fall) begin
        r_idle_cnt <= '0;
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= 4'd0;
          // r_frame[0] = start, [8:1] = data, [9] = parity; stop bit is on the line now
          if (!r_frame[0] && odd_parity(r_frame[9:1]) && r_ps2d_s2) begin
            r_rx_byte  <= r_frame[8:1];
            r_rx_valid <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end else begin
          r_frame   <= {r_ps2d_s2, r_frame[9:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if ((r_bit_cnt != 4'd0) && r_ps2c_s2) begin
        if (r_idle_cnt == TO_MAX) begin
          r_bit_cnt  <= 4'd0;
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + TO_W'(1);
        end
      end else begin
        r_idle_cnt <= '0;
      end
    end
  end

  // Key-state decoder: prefix/break handling, typematic filter and BCD press count.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      r_led_byte <= 8'd0;
      r_code     <= 8'd0;
      r_held     <= 1'b0;
      r_brk      <= 1'b0;
      r_ovf      <= 1'b0;
      r_cnt_lo   <= 4'd0;
      r_cnt_hi   <= 4'd0;
    end else if (r_rx_valid) begin
      r_led_byte <= r_rx_byte;
      if (r_rx_byte == 8'hE0) begin
        r_brk <= r_brk;
      end else if (r_rx_byte == 8'hF0) begin
        r_brk <= 1'b1;
      end else if (r_brk) begin
        r_brk <= 1'b0;
        if (r_held && (r_rx_byte == r_code)) begin
          r_held <= 1'b0;
        end
      end else if (!(r_held && (r_rx_byte == r_code))) begin
        r_code <= r_rx_byte;
        r_held <= 1'b1;
        if (r_cnt_lo == 4'd9) begin
          r_cnt_lo <= 4'd0;
          if (r_cnt_hi == 4'd9) begin
            r_cnt_hi <= 4'd0;
            r_ovf    <= 1'b1;
          end else begin
            r_cnt_hi <= r_cnt_hi + 4'd1;
          end
        end else begin
          r_cnt_lo <= r_cnt_lo + 4'd1;
        end
      end
    end
  end

  // Digit scan timer.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      r_div   <= '0;
      r_digit <= 3'd0;
    end else if (r_div == DIV_MAX) begin
      r_div   <= '0;
      r_digit <= r_digit + 3'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Pick the nibble for the active digit; key and ASCII digits go blank with no key held.
  always_comb begin
    w_nib   = 4'h0;
    w_blank = 1'b1;
    case (r_digit)
      3'd0:    begin w_nib = r_code[3:0];  w_blank = ~r_held; end
      3'd1:    begin w_nib = r_code[7:4];  w_blank = ~r_held; end
      3'd2:    begin w_nib = w_ascii[3:0]; w_blank = ~r_held; end
      3'd3:    begin w_nib = w_ascii[7:4]; w_blank = ~r_held; end
      3'd4:    begin w_nib = r_cnt_lo;     w_blank = 1'b0;    end
      3'd5:    begin w_nib = r_cnt_hi;     w_blank = 1'b0;    end
      default: begin w_nib = 4'h0;         w_blank = 1'b1;    end
    endcase
    if (w_blank) begin
      w_seg = 7'h7F;
    end else begin
      w_seg = hex_font(w_nib);
    end
  end

  // Registered pin drivers.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      r_seg <= 7'h7F;
      r_an  <= 8'hFF;
      r_led <= 16'h0000;
    end else begin
      r_seg <= w_seg;
      r_an  <= ~(8'd1 << r_digit);
      r_led <= {r_ovf, r_err, r_held, 5'd0, r_led_byte};
    end
  end

  assign io.SEG = r_seg;
  assign io.AN  = r_an;
  assign io.DP  = 1'b1;
  assign io.LED = r_led;

endmodule

// File: tb/tb_inout_lab.sv
// Randomised scoreboard bench for inout_lab: a keystroke-level model predicts LEDs and digits.
module tb_inout_lab;

  localparam int HALF    = 5;
  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst;
  inout_lab_if io();

  inout_lab #(.DIGIT_CYCLES(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLK100MHZ(clk), .BTNC(rst), .io(io)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]     led;
    logic [7:0][6:0] seg;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_busy = 1'b0;

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  string      keys = "abcdefghijklmnopqrstuvwxyz0123456789";
  logic [7:0] codes [36] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                             8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                             8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
                             8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                             8'h3E, 8'h46};

  // keyboard-level model state
  bit         m_held, m_brk, m_ovf, m_err;
  logic [7:0] m_code, m_byte;
  int         m_count;

  function automatic logic [7:0] ascii_of(input logic [7:0] b);
    for (int i = 0; i < 36; i++) if (codes[i] == b) return 8'(keys[i]);
    return 8'h00;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_brk = 0; m_ovf = 0; m_err = 0;
    m_code = 8'h00; m_byte = 8'h00; m_count = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      m_err = 1;
    end else begin
      m_byte = b;
      if (b == 8'hE0) begin
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else if (m_brk) begin
        if (m_held && b == m_code) m_held = 0;
        m_brk = 0;
      end else if (!(m_held && b == m_code)) begin
        m_code = b;
        m_held = 1;
        if (m_count == 99) m_ovf = 1;
        m_count = (m_count + 1) % 100;
      end
    end
  endtask

  task automatic push_expected();
    exp_t       e;
    logic [7:0] a;
    a = ascii_of(m_code);
    e.led = {m_ovf, m_err, m_held, 5'd0, m_byte};
    for (int d = 0; d < 8; d++) e.seg[d] = 7'h7F;
    if (m_held) begin
      e.seg[0] = font[m_code % 16];
      e.seg[1] = font[m_code / 16];
      e.seg[2] = font[a % 16];
      e.seg[3] = font[a / 16];
    end
    e.seg[4] = font[m_count % 10];
    e.seg[5] = font[m_count / 10];
    sb.push_back(e);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      io.PS2_DATA = f[i];
      wait_clks(HALF);
      io.PS2_CLK = 1'b0;
      wait_clks(HALF);
      io.PS2_CLK = 1'b1;
    end
    io.PS2_DATA = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad = 1'b0);
    send_bits(b, bad, 11);
    model_byte(b, bad);
    wait_clks(6);
    push_expected();
    wait_clks(4);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || mon_busy) && t < 2000) begin
      wait_clks(1);
      t++;
    end
    if (t >= 2000) chk("drain_timeout", 16'd1, 16'd0);
  endtask

  task automatic do_reset();
    drain();
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    model_reset();
    wait_clks(2);
    push_expected();
  endtask

  // Monitor: pops a prediction and checks LEDs and every scanned digit.
  initial begin : monitor
    exp_t       e;
    logic [7:0] pat;
    int         t;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        mon_busy = 1'b1;
        e = sb.pop_front();
        chk("led", io.LED, e.led);
        chk("an_onehot", 16'($countones(~io.AN)), 16'd1);
        for (int d = 0; d < 8; d++) begin
          pat = ~(8'd1 << d);
          t = 0;
          while (io.AN !== pat && t < 64) begin
            @(negedge clk);
            t++;
          end
          if (t >= 64) chk($sformatf("an_digit%0d_timeout", d), {8'd0, io.AN}, {8'd0, pat});
          else chk($sformatf("seg_digit%0d", d), {9'd0, io.SEG}, {9'd0, e.seg[d]});
        end
        mon_busy = 1'b0;
      end
    end
  end

  logic [7:0] pool [8] = '{8'h15, 8'h1D, 8'h1C, 8'h45, 8'hF0, 8'hF0, 8'hE0, 8'h32};

  initial begin : stim
    logic [7:0] b;
    bit         bad;
    io.PS2_CLK  = 1'b1;
    io.PS2_DATA = 1'b1;
    rst = 1'b1;
    model_reset();
    wait_clks(3);
    chk("reset_seg", {9'd0, io.SEG}, 16'h007F);
    chk("reset_an",  {8'd0, io.AN},  16'h00FF);
    chk("reset_led", io.LED,         16'h0000);
    chk("reset_dp",  {15'd0, io.DP}, 16'h0001);
    rst = 1'b0;
    wait_clks(2);
    push_expected();

    send(8'h15);
    send(8'hF0); send(8'h15);
    send(8'h1D); send(8'h1D); send(8'hF0); send(8'h1D);
    send(8'h15, 1'b1);
    send(8'h1C); send(8'hF0); send(8'h1C);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 7)];
      bad = ($urandom_range(0, 7) == 0);
      send(b, bad);
    end

    drain();
    send_bits(8'h1D, 1'b0, 5);
    do_reset();
    send(8'h45);

    do_reset();
    for (int i = 0; i < 100; i++) begin
      b = (i % 2 == 1) ? 8'h1D : 8'h15;
      send(b); send(8'hF0); send(b);
    end
    drain();
    send_bits(8'h15, 1'b0, 5);
    wait_clks(TIMEOUT + 50);
    send(8'h1C);

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
